// File: rtl/aes_key_expand_if.sv
// Handshake bundle between the AES-128 key schedule and its consumer.
// The slave side is the key expander; the master side requests runs and accepts keys.
interface aes_key_expand_if;
    logic         start;
    logic [0:127] key;
    logic         rk_valid;
    logic         rk_ready;
    logic [3:0]   rk_round;
    logic [0:127] rk;
    logic         busy;
    logic         done;

    modport slave (
        input  start, key, rk_ready,
        output rk_valid, rk_round, rk, busy, done
    );

    modport master (
        output start, key, rk_ready,
        input  rk_valid, rk_round, rk, busy, done
    );
endinterface

// File: rtl/aes_key_expand.sv
// Iterative AES-128 key schedule: presents round keys 0..10, one per accepted handshake.
// Byte 0 sits in bits [0:7]; word w0 in bits [0:31].

module aes_sbox (
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);
    // Row-major forward S-box; entry n occupies bits [8n : 8n+7].
    localparam logic [0:2047] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign o_byte = SBOX_TABLE[{i_byte, 3'b000} +: 8];
endmodule

module aes_key_expand (
    input  logic              clk,
    input  logic              rst_n,
    aes_key_expand_if.slave   bus
);
    typedef enum logic {
        S_IDLE,
        S_EMIT
    } state_t;

    state_t       r_state;
    logic [0:127] r_rk;
    logic [3:0]   r_rk_round;
    logic         r_rk_valid;
    logic         r_busy;
    logic         r_done;
    logic [7:0]   r_rcon;

    logic [0:31]  w_w3;
    logic [0:31]  w_rot;
    logic [0:31]  w_sub;
    logic [0:31]  w_t;
    logic [0:31]  w_n0;
    logic [0:31]  w_n1;
    logic [0:31]  w_n2;
    logic [0:31]  w_n3;
    logic [0:127] w_next_rk;
    logic [7:0]   w_rcon_next;
    logic         w_handshake;

    assign w_w3  = r_rk[96:127];
    assign w_rot = {w_w3[8:31], w_w3[0:7]};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_subword
            aes_sbox u_sbox (
                .i_byte (w_rot[8*gi +: 8]),
                .o_byte (w_sub[8*gi +: 8])
            );
        end
    endgenerate

    // Next key is purely combinational from the registered key.
    assign w_t       = w_sub ^ {r_rcon, 24'h000000};
    assign w_n0      = r_rk[0:31]   ^ w_t;
    assign w_n1      = r_rk[32:63]  ^ w_n0;
    assign w_n2      = r_rk[64:95]  ^ w_n1;
    assign w_n3      = r_rk[96:127] ^ w_n2;
    assign w_next_rk = {w_n0, w_n1, w_n2, w_n3};

    assign w_rcon_next = {r_rcon[6:0], 1'b0} ^ (r_rcon[7] ? 8'h1b : 8'h00);
    assign w_handshake = r_rk_valid && bus.rk_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_rk       <= '0;
            r_rk_round <= 4'd0;
            r_rk_valid <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_rcon     <= 8'h01;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_rk       <= bus.key;
                        r_rk_round <= 4'd0;
                        r_rcon     <= 8'h01;
                        r_rk_valid <= 1'b1;
                        r_busy     <= 1'b1;
                        r_state    <= S_EMIT;
                    end
                end
                S_EMIT: begin
                    if (w_handshake) begin
                        if (r_rk_round == 4'd10) begin
                            r_rk_valid <= 1'b0;
                            r_busy     <= 1'b0;
                            r_done     <= 1'b1;
                            r_state    <= S_IDLE;
                        end else begin
                            r_rk       <= w_next_rk;
                            r_rk_round <= r_rk_round + 4'd1;
                            r_rcon     <= w_rcon_next;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.rk_valid = r_rk_valid;
    assign bus.rk_round = r_rk_round;
    assign bus.rk       = r_rk;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
endmodule

// File: tb/tb_aes_key_expand.sv
// Scoreboard bench for aes_key_expand: a reference key schedule (S-box derived from
// GF(2^8) inversion) queues the expected keys; every accepted handshake is popped and compared.
module tb_aes_key_expand;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    aes_key_expand_if bus();

    aes_key_expand dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    typedef struct {
        logic [3:0]   round;
        logic [127:0] key;
    } exp_t;

    localparam logic [127:0] KEY_A   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] KEY_A1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] KEY_A10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] KEY_B   = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] KEY_B10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    localparam logic [127:0] KEY_C   = 128'hdeadbeef0123456789abcdeffedcba98;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int done_count = 0;
    exp_t sb[$];
    logic mon_hold = 1'b0;
    logic [127:0] hold_rk = '0;
    logic [3:0] hold_round = '0;

    always @(posedge clk) cyc++;

    // ---------------- reference model ----------------
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = xt(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox_ref(input logic [7:0] v);
        logic [7:0] inv;
        logic [7:0] r;
        logic [7:0] s;
        inv = 8'h00;
        if (v != 8'h00)
            for (int y = 1; y < 256; y++)
                if (gmul(v, y[7:0]) == 8'h01) inv = y[7:0];
        r = inv;
        s = inv;
        for (int i = 0; i < 4; i++) begin
            r = {r[6:0], r[7]};
            s ^= r;
        end
        return s ^ 8'h63;
    endfunction

    function automatic logic [127:0] next_key(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] rot;
        logic [31:0] t;
        logic [31:0] n0, n1, n2, n3;
        rot = {k[23:0], k[31:24]};
        t = {sbox_ref(rot[31:24]), sbox_ref(rot[23:16]), sbox_ref(rot[15:8]), sbox_ref(rot[7:0])}
            ^ {rc, 24'h000000};
        n0 = k[127:96] ^ t;
        n1 = k[95:64] ^ n0;
        n2 = k[63:32] ^ n1;
        n3 = k[31:0] ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    task automatic push_run(input logic [127:0] key);
        logic [127:0] k;
        logic [7:0] rc;
        exp_t e;
        k = key;
        rc = 8'h01;
        for (int r = 0; r <= 10; r++) begin
            e.round = r[3:0];
            e.key = k;
            sb.push_back(e);
            k = next_key(k, rc);
            rc = xt(rc);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        exp_t e;
        if (bus.done) done_count++;
        if (rst_n && mon_hold) begin
            checks++;
            if (bus.rk_valid !== 1'b1 || bus.rk !== hold_rk || bus.rk_round !== hold_round) begin
                failures++;
                $display("FAIL hold_stable: got valid=%b round=%0d rk=%h, want valid=1 round=%0d rk=%h",
                         bus.rk_valid, bus.rk_round, bus.rk, hold_round, hold_rk);
            end
        end
        mon_hold = rst_n && bus.rk_valid && !bus.rk_ready;
        hold_rk = bus.rk;
        hold_round = bus.rk_round;
        if (rst_n && bus.rk_valid && bus.rk_ready) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected: got round=%0d rk=%h with nothing expected", bus.rk_round, bus.rk);
            end else begin
                e = sb.pop_front();
                if (bus.rk_round !== e.round || bus.rk !== e.key) begin
                    failures++;
                    $display("FAIL sb_key: got round=%0d rk=%h, want round=%0d rk=%h",
                             bus.rk_round, bus.rk, e.round, e.key);
                end else begin
                    $display("txn round=%0d rk=%h", bus.rk_round, bus.rk);
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Drives a start that the DUT is expected to accept; e is the cycle count right after
    // the accepting edge, so round k is visible while cyc == e + k.
    task automatic start_run(input logic [127:0] k, output int e);
        bus.key = k;
        bus.start = 1'b1;
        push_run(k);
        tick();
        e = cyc;
        bus.start = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.key = '0;
        bus.rk_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus.rk_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b want 0", bus.rk_valid); end
        checks++;
        if (bus.rk_round !== 4'd0) begin failures++; $display("FAIL reset_round: got %0d want 0", bus.rk_round); end
        checks++;
        if (bus.rk !== 128'h0) begin failures++; $display("FAIL reset_rk: got %h want 0", bus.rk); end
        checks++;
        if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        checks++;
        if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b want 0", bus.done); end
        #1 rst_n = 1'b1;
        tick();
        $display("test_reset complete");
    endtask

    task automatic test_fips_vector;
        int e, r10_cyc, done_cyc;
        bit seen0, seen1;
        r10_cyc = -1;
        done_cyc = -1;
        seen0 = 0;
        seen1 = 0;
        bus.rk_ready = 1'b1;
        start_run(KEY_A, e);
        for (int i = 0; i < 40 && done_cyc < 0; i++) begin
            @(negedge clk);
            if (bus.rk_valid && bus.rk_round == 4'd0 && !seen0) begin
                seen0 = 1;
                checks++;
                if (bus.rk !== KEY_A) begin failures++; $display("FAIL fips_round0: got %h want %h", bus.rk, KEY_A); end
            end
            if (bus.rk_valid && bus.rk_round == 4'd1 && !seen1) begin
                seen1 = 1;
                checks++;
                if (bus.rk !== KEY_A1) begin failures++; $display("FAIL fips_round1: got %h want %h", bus.rk, KEY_A1); end
            end
            if (bus.rk_valid && bus.rk_round == 4'd10) begin
                r10_cyc = cyc;
                checks++;
                if (bus.rk !== KEY_A10) begin failures++; $display("FAIL fips_round10: got %h want %h", bus.rk, KEY_A10); end
            end
            if (bus.done) begin
                done_cyc = cyc;
                checks++;
                if (bus.busy !== 1'b0) begin failures++; $display("FAIL fips_busy_at_done: got %b want 0", bus.busy); end
            end
        end
        checks++;
        if (r10_cyc - e != 10) begin failures++; $display("FAIL fips_round10_latency: got %0d want 10", r10_cyc - e); end
        checks++;
        if (done_cyc - e != 11) begin failures++; $display("FAIL fips_done_latency: got %0d want 11", done_cyc - e); end
        @(negedge clk);
        checks++;
        if (bus.done !== 1'b0) begin failures++; $display("FAIL fips_done_pulse: got %b want 0", bus.done); end
        checks++;
        if (sb.size() != 0) begin failures++; $display("FAIL fips_sb_left: got %0d want 0", sb.size()); end
        $display("test_fips_vector complete");
    endtask

    task automatic test_ready_random;
        int e, d0;
        bit got;
        got = 0;
        d0 = done_count;
        bus.rk_ready = 1'b0;
        start_run(KEY_A, e);
        for (int i = 0; i < 300 && !got; i++) begin
            bus.rk_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (bus.done) got = 1;
            @(posedge clk);
            #1;
        end
        bus.rk_ready = 1'b1;
        repeat (3) tick();
        checks++;
        if (!got) begin failures++; $display("FAIL random_timeout: got no done want done within 300 cycles"); end
        checks++;
        if (done_count - d0 != 1) begin failures++; $display("FAIL random_done_count: got %0d want 1", done_count - d0); end
        checks++;
        if (sb.size() != 0) begin failures++; $display("FAIL random_sb_left: got %0d want 0", sb.size()); end
        $display("test_ready_random complete");
    endtask

    task automatic test_start_ignored;
        int e, d0;
        bit got;
        got = 0;
        d0 = done_count;
        bus.rk_ready = 1'b1;
        start_run(KEY_A, e);
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (bus.done) begin
                got = 1;
                bus.start = 1'b0;
            end else if (bus.rk_valid && (bus.rk_round == 4'd3 || bus.rk_round == 4'd7)) begin
                bus.start = 1'b1;
                bus.key = KEY_C;
                checks++;
                if (bus.busy !== 1'b1) begin failures++; $display("FAIL ignore_busy: got %b want 1", bus.busy); end
            end else begin
                bus.start = 1'b0;
            end
        end
        repeat (2) @(negedge clk);
        checks++;
        if (!got) begin failures++; $display("FAIL ignore_timeout: got no done want done"); end
        checks++;
        if (bus.rk_valid !== 1'b0) begin failures++; $display("FAIL ignore_idle_valid: got %b want 0", bus.rk_valid); end
        checks++;
        if (done_count - d0 != 1) begin failures++; $display("FAIL ignore_done_count: got %0d want 1", done_count - d0); end
        checks++;
        if (sb.size() != 0) begin failures++; $display("FAIL ignore_sb_left: got %0d want 0", sb.size()); end
        #1;
        $display("test_start_ignored complete");
    endtask

    task automatic test_reset_midrun;
        int e, d0;
        bit hit, got, seen0;
        hit = 0;
        got = 0;
        seen0 = 0;
        bus.rk_ready = 1'b1;
        start_run(KEY_A, e);
        for (int i = 0; i < 20 && !hit; i++) begin
            @(negedge clk);
            if (bus.rk_valid && bus.rk_round == 4'd5) hit = 1;
        end
        checks++;
        if (!hit) begin failures++; $display("FAIL rst_mid_timeout: got no round 5 want round 5"); end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.rk_valid !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0 ||
            bus.rk_round !== 4'd0 || bus.rk !== 128'h0) begin
            failures++;
            $display("FAIL rst_mid_async: got valid=%b busy=%b done=%b round=%0d rk=%h want all 0",
                     bus.rk_valid, bus.busy, bus.done, bus.rk_round, bus.rk);
        end
        sb.delete();
        d0 = done_count;
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (done_count != d0 || bus.rk_valid !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_no_done: got done_pulses=%0d valid=%b want 0 and 0", done_count - d0, bus.rk_valid);
        end
        tick();
        start_run(KEY_B, e);
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (bus.rk_valid && bus.rk_round == 4'd0 && !seen0) begin
                seen0 = 1;
                checks++;
                if (bus.rk !== KEY_B) begin failures++; $display("FAIL rst_restart_round0: got %h want %h", bus.rk, KEY_B); end
            end
            if (bus.rk_valid && bus.rk_round == 4'd10) begin
                checks++;
                if (bus.rk !== KEY_B10) begin failures++; $display("FAIL rst_restart_round10: got %h want %h", bus.rk, KEY_B10); end
            end
            if (bus.done) got = 1;
        end
        checks++;
        if (!got || !seen0) begin failures++; $display("FAIL rst_restart_timeout: got done=%b round0=%b want 1 1", got, seen0); end
        checks++;
        if (sb.size() != 0) begin failures++; $display("FAIL rst_restart_sb_left: got %0d want 0", sb.size()); end
        #1;
        $display("test_reset_midrun complete");
    endtask

    task automatic test_back_to_back;
        bit got;
        got = 0;
        bus.rk_ready = 1'b1;
        bus.key = KEY_A;
        bus.start = 1'b1;
        push_run(KEY_A);
        tick();
        bus.key = KEY_B;
        push_run(KEY_B);
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (bus.done) got = 1;
        end
        checks++;
        if (!got) begin failures++; $display("FAIL b2b_first_timeout: got no done want done"); end
        @(negedge clk);
        checks++;
        if (bus.rk_valid !== 1'b1 || bus.rk_round !== 4'd0 || bus.rk !== KEY_B || bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL b2b_restart: got valid=%b round=%0d busy=%b rk=%h want 1 0 1 %h",
                     bus.rk_valid, bus.rk_round, bus.busy, bus.rk, KEY_B);
        end
        bus.start = 1'b0;
        got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (bus.done) got = 1;
        end
        checks++;
        if (!got) begin failures++; $display("FAIL b2b_second_timeout: got no done want done"); end
        checks++;
        if (sb.size() != 0) begin failures++; $display("FAIL b2b_sb_left: got %0d want 0", sb.size()); end
        #1;
        $display("test_back_to_back complete");
    endtask

    initial begin
        bus.start = 1'b0;
        bus.key = '0;
        bus.rk_ready = 1'b0;
        test_reset();
        test_fips_vector();
        test_ready_random();
        test_start_ignored();
        test_reset_midrun();
        test_back_to_back();
        repeat (2) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
